// File: rtl/bits_ifetch_if.sv
// Bundle of the fetch handshake, instruction ROM port and bit-buffer consumer signals.
// The fetch unit uses the slave modport; the surrounding logic uses master.
interface bits_ifetch_if;
  logic         mem_req_b;
  logic         mem_ack_b;
  logic         imem_ceb;
  logic [11:0]  imem_addr;
  logic [127:0] imem_rdata;
  logic [15:0]  imem_byte_valid;
  logic [11:0]  last_addr;
  logic         consume_valid;
  logic [8:0]   consume_bits;
  logic [255:0] instruction_cache_word;
  logic [8:0]   cache_bits;
  logic         space_available;
  logic         done_reading_memory;
  logic         underflow;

  modport master (
    output mem_req_b, imem_rdata, imem_byte_valid, last_addr, consume_valid, consume_bits,
    input  mem_ack_b, imem_ceb, imem_addr, instruction_cache_word, cache_bits,
           space_available, done_reading_memory, underflow
  );

  modport slave (
    input  mem_req_b, imem_rdata, imem_byte_valid, last_addr, consume_valid, consume_bits,
    output mem_ack_b, imem_ceb, imem_addr, instruction_cache_word, cache_bits,
           space_available, done_reading_memory, underflow
  );
endinterface

// File: rtl/bits_ifetch.sv
// Instruction fetch unit: reads 128-bit ROM words on request and appends their valid bytes
// to a left-aligned 256-bit bit buffer that the consumer drains from the top.
module bits_ifetch (
  input logic          clk,
  input logic          resetB,
  bits_ifetch_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StAppend, StAck} state_e;

  state_e       r_state;
  logic         r_mem_ack_b;
  logic         r_imem_ceb;
  logic [11:0]  r_imem_addr;
  logic [11:0]  r_ptr;
  logic [127:0] r_data;
  logic [15:0]  r_bv;
  logic [255:0] r_buf;
  logic [8:0]   r_cache_bits;
  logic         r_space;
  logic         r_done;
  logic         r_underflow;

  logic         w_over;
  logic [8:0]   w_drop;
  logic [8:0]   w_base;
  logic [8:0]   w_cache_next;
  logic [4:0]   w_nbytes;
  logic [127:0] w_masked;
  logic [255:0] w_buf_next;

  // Consume is applied first; an appended word lands right after the surviving bits.
  always_comb begin
    w_over   = bus.consume_valid && (bus.consume_bits > r_cache_bits);
    w_drop   = '0;
    if (bus.consume_valid) begin
      w_drop = w_over ? r_cache_bits : bus.consume_bits;
    end
    w_base   = r_cache_bits - w_drop;
    w_masked = '0;
    w_nbytes = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_bv[i]) begin
        w_masked[8*i +: 8] = r_data[8*i +: 8];
        w_nbytes           = w_nbytes + 5'd1;
      end
    end
    w_buf_next   = r_buf << w_drop;
    w_cache_next = w_base;
    if (r_state == StAppend) begin
      w_buf_next   = w_buf_next | ({w_masked, 128'b0} >> w_base);
      w_cache_next = w_base + {1'b0, w_nbytes, 3'b000};
    end
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      r_state      <= StIdle;
      r_mem_ack_b  <= 1'b1;
      r_imem_ceb   <= 1'b1;
      r_imem_addr  <= '0;
      r_ptr        <= '0;
      r_data       <= '0;
      r_bv         <= '0;
      r_buf        <= '0;
      r_cache_bits <= '0;
      r_space      <= 1'b1;
      r_done       <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_buf        <= w_buf_next;
      r_cache_bits <= w_cache_next;
      r_space      <= (w_cache_next <= 9'd128);
      if (w_over) begin
        r_underflow <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (!bus.mem_req_b) begin
            if (r_space && !r_done) begin
              r_state     <= StRead;
              r_imem_ceb  <= 1'b0;
              r_imem_addr <= r_ptr;
            end else begin
              r_state     <= StAck;
              r_mem_ack_b <= 1'b0;
            end
          end
        end
        StRead: begin
          r_imem_ceb <= 1'b1;
          r_state    <= StWait;
        end
        StWait: begin
          r_data  <= bus.imem_rdata;
          r_bv    <= bus.imem_byte_valid;
          r_state <= StAppend;
        end
        StAppend: begin
          if (r_ptr == bus.last_addr) begin
            r_done <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 12'd1;
          end
          r_mem_ack_b <= 1'b0;
          r_state     <= StAck;
        end
        StAck: begin
          r_mem_ack_b <= 1'b1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.mem_ack_b              = r_mem_ack_b;
  assign bus.imem_ceb               = r_imem_ceb;
  assign bus.imem_addr              = r_imem_addr;
  assign bus.instruction_cache_word = r_buf;
  assign bus.cache_bits             = r_cache_bits;
  assign bus.space_available        = r_space;
  assign bus.done_reading_memory    = r_done;
  assign bus.underflow              = r_underflow;

endmodule

// File: tb/tb_bits_ifetch.sv
// Bench for bits_ifetch: directed fetch/consume scenarios, a consume vector table and random
// traffic, all checked every cycle against a bit-queue reference model.
module tb_bits_ifetch;

  logic clk = 1'b0;
  logic resetB;
  always #5 clk = ~clk;

  bits_ifetch_if bus ();

  bits_ifetch dut (
    .clk   (clk),
    .resetB(resetB),
    .bus   (bus.slave)
  );

  logic [127:0] rom_d [16];
  logic [15:0]  rom_v [16];

  // ROM returns data one cycle after chip enable
  always @(posedge clk) begin
    if (!bus.imem_ceb) begin
      bus.imem_rdata      <= rom_d[bus.imem_addr[3:0]];
      bus.imem_byte_valid <= rom_v[bus.imem_addr[3:0]];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model: buffer as a queue of bits, transaction timing as absolute edge numbers.
  bit mq[$];
  int m_ptr;
  bit m_done;
  bit m_uf;
  int last;
  int cyc;
  int m_idle_at;
  int m_app_at;
  int m_ack_at;
  int m_ceb_at;
  int m_ceb_addr;

  typedef struct {
    int cb;
    int exp_bits;
    bit exp_uf;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ptr     = 0;
    m_done    = 1'b0;
    m_uf      = 1'b0;
    cyc       = 0;
    m_idle_at = 0;
    m_app_at  = -1;
    m_ack_at  = -1;
    m_ceb_at  = -1;
  endtask

  task automatic do_reset();
    resetB = 1'b0;
    #1;
    chk("rst_ack", 256'(bus.mem_ack_b), 256'(1));
    chk("rst_ceb", 256'(bus.imem_ceb), 256'(1));
    chk("rst_addr", 256'(bus.imem_addr), 256'(0));
    chk("rst_word", bus.instruction_cache_word, 256'(0));
    chk("rst_bits", 256'(bus.cache_bits), 256'(0));
    chk("rst_space", 256'(bus.space_available), 256'(1));
    chk("rst_done", 256'(bus.done_reading_memory), 256'(0));
    chk("rst_uf", 256'(bus.underflow), 256'(0));
    @(negedge clk);
    resetB = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit req, input bit cv, input int cb);
    int n;
    logic [255:0] w;
    bus.mem_req_b     = req;
    bus.consume_valid = cv;
    bus.consume_bits  = 9'(cb);
    @(posedge clk);
    cyc++;
    if (cyc >= m_idle_at && !req) begin
      if (mq.size() <= 128 && !m_done) begin
        m_ceb_at   = cyc;
        m_ceb_addr = m_ptr;
        m_app_at   = cyc + 3;
        m_ack_at   = cyc + 3;
        m_idle_at  = cyc + 5;
      end else begin
        m_ack_at  = cyc;
        m_idle_at = cyc + 2;
      end
    end
    if (cv) begin
      n = cb;
      if (n > mq.size()) begin
        n    = mq.size();
        m_uf = 1'b1;
      end
      repeat (n) void'(mq.pop_front());
    end
    if (m_app_at == cyc) begin
      for (int b = 15; b >= 0; b--) begin
        if (rom_v[m_ceb_addr][b]) begin
          for (int k = 7; k >= 0; k--) mq.push_back(rom_d[m_ceb_addr][8*b+k]);
        end
      end
      if (m_ptr == last) m_done = 1'b1;
      else m_ptr++;
    end
    #1;
    w = '0;
    foreach (mq[i]) w[255-i] = mq[i];
    chk("mem_ack_b", 256'(bus.mem_ack_b), 256'(m_ack_at != cyc));
    chk("imem_ceb", 256'(bus.imem_ceb), 256'(m_ceb_at != cyc));
    if (m_ceb_at == cyc) chk("imem_addr", 256'(bus.imem_addr), 256'(m_ceb_addr));
    chk("cache_bits", 256'(bus.cache_bits), 256'(mq.size()));
    chk("cache_word", bus.instruction_cache_word, w);
    chk("space", 256'(bus.space_available), 256'(mq.size() <= 128));
    chk("done", 256'(bus.done_reading_memory), 256'(m_done));
    chk("underflow", 256'(bus.underflow), 256'(m_uf));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
  endtask

  initial begin
    logic [255:0] tmp;
    logic [15:0]  m16;
    int           nb;

    bus.mem_req_b     = 1'b1;
    bus.consume_valid = 1'b0;
    bus.consume_bits  = '0;
    resetB            = 1'b1;
    last              = 1;
    bus.last_addr     = 12'(last);
    for (int a = 0; a < 16; a++) begin
      rom_d[a] = {$urandom, $urandom, $urandom, $urandom};
      rom_v[a] = 16'hFFFF;
    end
    rom_d[0] = 128'hD2FE_28A1_5C3B_7E90_0F1E_2D3C_4B5A_6978;
    rom_d[1] = 128'hB7C4_1234_5678_9ABC_DEF0_0246_8ACE_1357;
    rom_v[2] = 16'hFF00;
    #2;
    do_reset();

    // Two full fetches fill the buffer, third request is acked without a fetch
    step(1'b0, 1'b0, 0);
    chk("req22_ceb", 256'(bus.imem_ceb), 256'(0));
    chk("req22_addr", 256'(bus.imem_addr), 256'(0));
    idle_steps(3);
    chk("req22_ack", 256'(bus.mem_ack_b), 256'(0));
    chk("req22_bits", 256'(bus.cache_bits), 256'(128));
    chk("req22_top", 256'(bus.instruction_cache_word[255:248]), 256'(8'hD2));
    chk("req22_space", 256'(bus.space_available), 256'(1));
    idle_steps(1);
    step(1'b0, 1'b0, 0);
    chk("req23_addr", 256'(bus.imem_addr), 256'(1));
    idle_steps(3);
    chk("req23_bits", 256'(bus.cache_bits), 256'(256));
    chk("req23_space", 256'(bus.space_available), 256'(0));
    chk("req23_done", 256'(bus.done_reading_memory), 256'(1));
    idle_steps(1);
    step(1'b0, 1'b0, 0);
    chk("req23_fast_ack", 256'(bus.mem_ack_b), 256'(0));
    chk("req23_no_ceb", 256'(bus.imem_ceb), 256'(1));
    idle_steps(1);

    // Consume vectors starting from a full buffer
    tbl[0] = '{cb: 0,   exp_bits: 256, exp_uf: 1'b0};
    tbl[1] = '{cb: 6,   exp_bits: 250, exp_uf: 1'b0};
    tbl[2] = '{cb: 100, exp_bits: 150, exp_uf: 1'b0};
    tbl[3] = '{cb: 130, exp_bits: 20,  exp_uf: 1'b0};
    tbl[4] = '{cb: 30,  exp_bits: 0,   exp_uf: 1'b1};
    tbl[5] = '{cb: 0,   exp_bits: 0,   exp_uf: 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, tbl[i].cb);
      chk("tbl_bits", 256'(bus.cache_bits), 256'(tbl[i].exp_bits));
      chk("tbl_uf", 256'(bus.underflow), 256'(tbl[i].exp_uf));
    end
    chk("req26_empty", bus.instruction_cache_word, 256'(0));
    step(1'b0, 1'b1, 0);
    idle_steps(3);
    chk("req26_sticky", 256'(bus.underflow), 256'(1));

    // Consume landing on the append cycle
    last          = 5;
    bus.last_addr = 12'(last);
    do_reset();
    step(1'b0, 1'b0, 0);
    idle_steps(4);
    step(1'b0, 1'b0, 0);
    idle_steps(2);
    step(1'b1, 1'b1, 6);
    chk("req24_bits", 256'(bus.cache_bits), 256'(250));
    chk("req24_first", 256'(bus.instruction_cache_word[133 -: 8]), 256'(rom_d[1][127:120]));
    idle_steps(1);

    // Partial word (upper 8 bytes valid)
    step(1'b1, 1'b1, 200);
    step(1'b0, 1'b0, 0);
    idle_steps(3);
    chk("req25_bits", 256'(bus.cache_bits), 256'(114));
    tmp = bus.instruction_cache_word << 114;
    chk("req25_tail_zero", tmp, 256'(0));
    idle_steps(1);

    // Reset during WAIT abandons the fetch
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    do_reset();
    idle_steps(8);
    step(1'b0, 1'b0, 0);
    chk("req21_addr0", 256'(bus.imem_addr), 256'(0));
    idle_steps(4);

    // Random traffic
    for (int r = 0; r < 2; r++) begin
      last          = $urandom_range(2, 9);
      bus.last_addr = 12'(last);
      m16           = 16'hFFFF;
      for (int a = 0; a < 10; a++) begin
        rom_d[a] = {$urandom, $urandom, $urandom, $urandom};
        nb       = $urandom_range(0, 16);
        rom_v[a] = (nb == 0) ? 16'h0000 : (m16 << (16 - nb));
      end
      do_reset();
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1,
             ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 5) ? $urandom_range(0, 300) : $urandom_range(0, 48));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bits_ifetch.md
BITS_IFETCH -- requirements
Module: bits_ifetch

Interface
REQ-001 SHALL have ports, clock and reset first:
  clk  in  1  system clock, all state on rising edge
  resetB  in  1  reset, asynchronous, active-low
  mem_req_b  in  1  active-low fetch request from packet FSM
  mem_ack_b  out  1  active-low fetch acknowledge, one-cycle pulse
  imem_ceb  out  1  active-low instruction ROM chip enable
  imem_addr  out  12  instruction ROM word address
  imem_rdata  in  128  ROM data, byte 15 at [127:120], valid 1 cycle after imem_ceb low
  imem_byte_valid  in  16  per-byte valid, bit15 = byte [127:120], contiguous from bit15
  last_addr  in  12  address of last valid ROM word, static while not IDLE
  consume_valid  in  1  discard request strobe
  consume_bits  in  9  number of bits to discard from buffer head (0-256)
  instruction_cache_word  out  256  bit buffer, left-aligned, oldest bit at [255]
  cache_bits  out  9  number of valid bits in buffer (0-256)
  space_available  out  1  cache_bits <= 128
  done_reading_memory  out  1  word last_addr has been appended
  underflow  out  1  sticky: consume exceeded cache_bits

Function
REQ-002 SHALL implement states IDLE, READ, WAIT, APPEND, ACK.
REQ-003 IDLE: mem_req_b==0 and space_available==1 and done_reading_memory==0 -> READ; mem_req_b==0 otherwise -> ACK (no fetch); else stay.
REQ-004 READ: drive imem_ceb=0 for exactly this cycle with imem_addr = current fetch pointer; -> WAIT.
REQ-005 WAIT: capture imem_rdata and imem_byte_valid; -> APPEND.
REQ-006 APPEND: place the valid bytes of captured word MSB-first directly after the last valid bit; cache_bits += 8 x (number of valid bytes); if fetch pointer == last_addr set done_reading_memory else increment pointer; -> ACK.
REQ-007 ACK: mem_ack_b=0 for this one cycle only; -> IDLE. mem_ack_b SHALL be 1 in every other state.
REQ-008 Fetch latency: mem_req_b sampled low in IDLE -> mem_ack_b low 4 cycles later (READ, WAIT, APPEND, ACK).
REQ-009 Consume accepted in any state: buffer shifts left by consume_bits, zero fill from LSB, cache_bits -= consume_bits.
REQ-010 Consume and APPEND in same cycle: consume applied first, new data placed at offset (cache_bits - consume_bits); resulting cache_bits = old - consume + appended.
REQ-011 consume_bits > cache_bits: clamp to cache_bits (buffer becomes empty, all zeros), set underflow; underflow cleared only by reset.
REQ-012 consume_bits == 0 with consume_valid: no change.
REQ-013 Bits beyond cache_bits in instruction_cache_word SHALL always be 0.
REQ-014 Append when space_available guarantees no overflow (<=128 + 128 = 256); cache_bits width 9 bits holds 256 exactly.
REQ-015 imem_byte_valid==16'h0000: append nothing, pointer/done update still performed.
REQ-016 Once done_reading_memory==1 it SHALL stay 1 until reset; pointer SHALL not advance past last_addr.
REQ-017 space_available and done_reading_memory are registered, updated in the same cycle as cache_bits / pointer.
REQ-018 mem_req_b held low continuously: one acknowledged transaction per IDLE visit; re-entry to IDLE re-evaluates REQ-003.

Reset
REQ-019 resetB low asynchronously forces: state IDLE, mem_ack_b=1, imem_ceb=1, imem_addr=0, fetch pointer 0, instruction_cache_word=0, cache_bits=0, space_available=1, done_reading_memory=0, underflow=0.
REQ-020 Reset mid-transaction (READ/WAIT/APPEND/ACK) SHALL abandon it; no ack issued after release; captured data discarded.
REQ-021 After resetB release, first fetch from address 0.

Verification
REQ-022 last_addr=1, ROM[0]=128'hD2FE28..(all bytes valid); pulse mem_req_b -> imem_ceb low 1 cycle addr 0, ack 4 cycles after request, cache_bits=128, [255:248]=8'hD2, space_available=1.
REQ-023 Second request -> addr 1 read, cache_bits=256, space_available=0, done_reading_memory=1; third request -> immediate ACK next cycle, no imem_ceb.
REQ-024 Buffer 128 bits, consume_bits=6 in the APPEND cycle with 16 valid bytes -> cache_bits=250, new word's first bit at [255-122].
REQ-025 Word with imem_byte_valid=16'hFF00 -> cache_bits grows by 64; instruction_cache_word bits below new cache_bits all 0.
REQ-026 cache_bits=20, consume_bits=30 -> cache_bits=0, buffer all 0, underflow=1 and stays 1 after further valid traffic.
REQ-027 Assert resetB low during WAIT -> all outputs at REQ-019 values immediately; no mem_ack_b pulse after release until a new request.
